// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and width helpers for the LED pattern sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } led_seq_state_t;

    // Width of the step index; a one-bit floor keeps degenerate tables legal.
    function automatic int led_sw(input int num_steps);
        return (num_steps < 2) ? 1 : $clog2(num_steps);
    endfunction

    // Width of the prescale counter, which must hold 0..PRESCALE-1.
    function automatic int led_cnt_w(input int prescale);
        return (prescale < 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/pattern/pin bundle between the top level and the sequencer.
// Latency: n/a (wires only); duty exists only when LED_PWM_EN is defined.
// Backpressure: none, all controls are single-cycle pulses or levels.
interface led_pattern_sequencer_if #(
    parameter int NUM_OUT  = 2,
    parameter int SW       = 2,
    parameter int PWM_BITS = 4
);
    logic                start;
    logic                stop;
    logic                pat_we;
    logic [SW-1:0]       pat_addr;
    logic [NUM_OUT-1:0]  pat_data;
`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] duty;
`endif
    logic [NUM_OUT-1:0]  pins;
    logic                busy;
    logic [SW-1:0]       step;

`ifdef LED_PWM_EN
    modport master (output start, stop, pat_we, pat_addr, pat_data, duty,
                    input  pins, busy, step);
    modport slave  (input  start, stop, pat_we, pat_addr, pat_data, duty,
                    output pins, busy, step);
`else
    modport master (output start, stop, pat_we, pat_addr, pat_data,
                    input  pins, busy, step);
    modport slave  (input  start, stop, pat_we, pat_addr, pat_data,
                    output pins, busy, step);
`endif
endinterface

// File: rtl/led_pattern_sequencer_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 while enabled, clears when not.
// Latency: tick is combinational on the terminal count.
// Backpressure: none; dropping en restarts the count from zero.
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int PRESCALE = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int             CW   = led_cnt_w(PRESCALE);
    localparam logic [CW-1:0]  TERM = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == TERM);

    // Next count: wrap at the terminal value, hold at zero while disabled.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps a small pattern table onto the pins at a prescaled rate (PWM dimming with LED_PWM_EN).
// Latency: pins register table[step] one cycle after the step is current; table writes show two cycles after pat_we.
// Backpressure: none; start in RUN and stop in IDLE are ignored, stop beats start.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_OUT   = 2,
    parameter int NUM_STEPS = 4,
    parameter int PRESCALE  = 12,
    parameter int PWM_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    led_pattern_sequencer_if.slave bus
);
    localparam int            SW   = led_sw(NUM_STEPS);
    localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);

    led_seq_state_t     state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [NUM_OUT-1:0] pins_q, pins_d;
    logic [NUM_OUT-1:0] table_q [NUM_STEPS];
    logic               run_en;
    logic               tick;
    logic               pwm_on;

    // Prescaler runs only on RUN cycles that continue into RUN, so a stop leaves it at zero.
    assign run_en = (state_q == RUN) && !bus.stop;

    led_seq_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .tick (tick)
    );

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;

    // Free-running PWM phase counter.
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end

    assign pwm_on = (pwm_cnt_q < bus.duty);
`else
    assign pwm_on = 1'b1;
`endif

    // FSM, step index and pin drive next-state; stop dominates start.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pins_d  = '0;
        if (state_q == IDLE) begin
            step_d = '0;
            if (bus.start && !bus.stop) state_d = RUN;
        end else if (bus.stop) begin
            state_d = IDLE;
            step_d  = '0;
        end else begin
            pins_d = table_q[step_q] & {NUM_OUT{pwm_on}};
            if (tick) step_d = (step_q == LAST) ? '0 : step_q + 1'b1;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            pins_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pins_q  <= pins_d;
        end
    end

    // Pattern table: cleared by reset, writable in any state; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= '0;
        end else if (bus.pat_we && (int'(bus.pat_addr) < NUM_STEPS)) begin
            table_q[bus.pat_addr] <= bus.pat_data;
        end
    end

    assign bus.pins = pins_q;
    assign bus.busy = (state_q == RUN);
    assign bus.step = step_q;
endmodule
